// File: rtl/lcd_mode_arbiter.sv
// Display-mode tracker and character-LCD front end: power-up init sequence, then a registered
// two-stage mux from the active channel to the panel. Optional macro: LCD_CLEAR_ON_SWITCH_EN.
module lcd_mode_arbiter #(
    parameter int unsigned N_MODES   = 12,
    parameter int unsigned MODE_W    = 4,
    parameter int unsigned PWR_DELAY = 70,
    parameter int unsigned CMD_HOLD  = 30,
    parameter logic [7:0]  FUNC_CMD  = 8'h3C,
    parameter logic [7:0]  DISP_CMD  = 8'h0C,
    parameter logic [7:0]  ENTRY_CMD = 8'h06,
    parameter logic [7:0]  CLEAR_CMD = 8'h01
) (
    input  logic                      CLK_1k,
    input  logic                      RESET,
    input  logic                      SEL_STB,
    input  logic [MODE_W-1:0]         SEL_CODE,
    input  logic                      HOME_STB,
    input  logic                      BACK_STB,
    input  logic [N_MODES*MODE_W-1:0] PARENT_MAP,
    input  logic [N_MODES-1:0]        VALID_MAP,
    input  logic [N_MODES-1:0]        CH_RS,
    input  logic [N_MODES-1:0]        CH_RW,
    input  logic [N_MODES*8-1:0]      CH_DATA,
    output logic [MODE_W-1:0]         MODE,
    output logic                      MODE_CHG,
    output logic                      PROGRAM_EN,
    output logic                      LCD_E,
    output logic                      LCD_RS,
    output logic                      LCD_RW,
    output logic [7:0]                LCD_DATA
);

    localparam int unsigned CNT_MAX = (PWR_DELAY > CMD_HOLD) ? PWR_DELAY : CMD_HOLD;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] PWR_TC  = CNT_W'(PWR_DELAY);
    localparam logic [CNT_W-1:0] HOLD_TC = CNT_W'(CMD_HOLD);
    localparam logic [3:0][7:0]  CMD_ROM = {CLEAR_CMD, ENTRY_CMD, DISP_CMD, FUNC_CMD};

    typedef enum logic [2:0] {
        S_DELAY,
        S_FUNC,
        S_DISP,
        S_ENTRY,
        S_PROG
`ifdef LCD_CLEAR_ON_SWITCH_EN
        , S_CLEAR
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [MODE_W-1:0]  mode_q, mode_d, mode_prev_q, parent;
    logic               mode_chg_q, sel_ok, parent_ok, mode_change;
    logic               ch_rs, ch_rw, st1_rs_q, st1_rw_q;
    logic [7:0]         ch_data, st1_data_q;
    logic               cmd_rs, cmd_rw;
    logic [7:0]         cmd_data;
    logic               lcd_rs_q, lcd_rw_q;
    logic [7:0]         lcd_data_q;

    // Per-mode lookups; a code with no matching entry falls back to channel/parent 0.
    always_comb begin
        sel_ok  = 1'b0;
        parent  = '0;
        ch_rs   = CH_RS[0];
        ch_rw   = CH_RW[0];
        ch_data = CH_DATA[7:0];
        for (int i = 0; i < N_MODES; i++) begin
            if (SEL_CODE == MODE_W'(i)) sel_ok = VALID_MAP[i];
            if (mode_q == MODE_W'(i)) begin
                parent  = PARENT_MAP[i*MODE_W +: MODE_W];
                ch_rs   = CH_RS[i];
                ch_rw   = CH_RW[i];
                ch_data = CH_DATA[i*8 +: 8];
            end
        end
    end

    assign parent_ok = (32'(parent) < N_MODES);

    always_comb begin
        mode_d = mode_q;
        if (SEL_STB) begin
            mode_d = sel_ok ? SEL_CODE : '0;
        end else if (HOME_STB) begin
            mode_d = '0;
        end else if (BACK_STB) begin
            mode_d = parent_ok ? parent : '0;
        end
    end

    assign mode_change = (mode_d != mode_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        cmd_rs   = 1'b0;
        cmd_rw   = 1'b0;
        cmd_data = '0;
        case (state_q)
            S_DELAY: begin
                cmd_rs = 1'b1;
                cmd_rw = 1'b1;
                if (cnt_q == PWR_TC) begin
                    state_d = S_FUNC;
                    cnt_d   = '0;
                end
            end
            S_FUNC: begin
                cmd_data = CMD_ROM[0];
                if (cnt_q == HOLD_TC) begin
                    state_d = S_DISP;
                    cnt_d   = '0;
                end
            end
            S_DISP: begin
                cmd_data = CMD_ROM[1];
                if (cnt_q == HOLD_TC) begin
                    state_d = S_ENTRY;
                    cnt_d   = '0;
                end
            end
            S_ENTRY: begin
                cmd_data = CMD_ROM[2];
                if (cnt_q == HOLD_TC) begin
                    state_d = S_PROG;
                    cnt_d   = '0;
                end
            end
            S_PROG: begin
                cnt_d = '0;
`ifdef LCD_CLEAR_ON_SWITCH_EN
                if (mode_change) state_d = S_CLEAR;
`endif
            end
`ifdef LCD_CLEAR_ON_SWITCH_EN
            S_CLEAR: begin
                cmd_data = CMD_ROM[3];
                // A further switch restarts the clear hold from zero.
                if (mode_change) begin
                    cnt_d = '0;
                end else if (cnt_q == HOLD_TC) begin
                    state_d = S_PROG;
                    cnt_d   = '0;
                end
            end
`endif
            default: begin
                state_d = S_DELAY;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK_1k or negedge RESET) begin
        if (!RESET) begin
            state_q     <= S_DELAY;
            cnt_q       <= '0;
            mode_q      <= '0;
            mode_prev_q <= '0;
            mode_chg_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            mode_prev_q <= mode_q;
            // Pulses in the cycle after MODE takes its new value.
            mode_chg_q  <= (mode_q != mode_prev_q);
        end
    end

    always_ff @(posedge CLK_1k or negedge RESET) begin
        if (!RESET) begin
            st1_rs_q   <= 1'b0;
            st1_rw_q   <= 1'b0;
            st1_data_q <= '0;
            lcd_rs_q   <= 1'b1;
            lcd_rw_q   <= 1'b1;
            lcd_data_q <= '0;
        end else begin
            st1_rs_q   <= ch_rs;
            st1_rw_q   <= ch_rw;
            st1_data_q <= ch_data;
            if (state_q == S_PROG) begin
                lcd_rs_q   <= st1_rs_q;
                lcd_rw_q   <= st1_rw_q;
                lcd_data_q <= st1_data_q;
            end else begin
                lcd_rs_q   <= cmd_rs;
                lcd_rw_q   <= cmd_rw;
                lcd_data_q <= cmd_data;
            end
        end
    end

    assign MODE       = mode_q;
    assign MODE_CHG   = mode_chg_q;
    assign PROGRAM_EN = (state_q == S_PROG);
    assign LCD_E      = CLK_1k;
    assign LCD_RS     = lcd_rs_q;
    assign LCD_RW     = lcd_rw_q;
    assign LCD_DATA   = lcd_data_q;

endmodule

// File: tb/tb_lcd_mode_arbiter.sv
// Directed bench for lcd_mode_arbiter (default build): init timing, mode strobes, mux latency,
// mid-init reset. Expected values are queued when stimulus is applied and popped on sampling.
module tb_lcd_mode_arbiter;

    logic        CLK_1k = 1'b0;
    logic        RESET  = 1'b0;
    logic        SEL_STB = 1'b0, HOME_STB = 1'b0, BACK_STB = 1'b0;
    logic [3:0]  SEL_CODE = '0;
    logic [47:0] PARENT_MAP;
    logic [11:0] VALID_MAP, CH_RS, CH_RW;
    logic [95:0] CH_DATA;
    logic [3:0]  MODE;
    logic        MODE_CHG, PROGRAM_EN, LCD_E, LCD_RS, LCD_RW;
    logic [7:0]  LCD_DATA;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        string      tag;
        logic [7:0] val;
    } exp_t;
    exp_t sb[$];

    lcd_mode_arbiter dut (
        .CLK_1k(CLK_1k), .RESET(RESET),
        .SEL_STB(SEL_STB), .SEL_CODE(SEL_CODE), .HOME_STB(HOME_STB), .BACK_STB(BACK_STB),
        .PARENT_MAP(PARENT_MAP), .VALID_MAP(VALID_MAP),
        .CH_RS(CH_RS), .CH_RW(CH_RW), .CH_DATA(CH_DATA),
        .MODE(MODE), .MODE_CHG(MODE_CHG), .PROGRAM_EN(PROGRAM_EN),
        .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_DATA(LCD_DATA)
    );

    always #5 CLK_1k = ~CLK_1k;

    // Edges since reset release.
    always @(posedge CLK_1k or negedge RESET) begin
        if (!RESET) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic push(input string tag, input logic [7:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [7:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed %h expected none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) @(negedge CLK_1k);
    endtask

    task automatic strobe(input logic s, input logic [3:0] code, input logic h, input logic b);
        SEL_STB  = s;
        SEL_CODE = code;
        HOME_STB = h;
        BACK_STB = b;
        @(negedge CLK_1k);
        SEL_STB  = 1'b0;
        HOME_STB = 1'b0;
        BACK_STB = 1'b0;
    endtask

    task automatic settle();
        repeat (3) @(negedge CLK_1k);
    endtask

    initial begin
        VALID_MAP = 12'hDFF;  // mode 9 not selectable
        CH_RS     = 12'hA5A;
        CH_RW     = 12'h3C3;
        for (int i = 0; i < 12; i++) begin
            CH_DATA[i*8 +: 8]    = 8'(8'h40 + i);
            PARENT_MAP[i*4 +: 4] = (i == 0) ? 4'd0 : 4'(i - 1);
        end
        CH_DATA[5*8 +: 8] = 8'h41;

        // Reset values
        repeat (2) @(negedge CLK_1k);
        push("rst_mode", 8'h00);     pop_check({4'h0, MODE});
        push("rst_chg", 8'h00);      pop_check({7'h0, MODE_CHG});
        push("rst_pen", 8'h00);      pop_check({7'h0, PROGRAM_EN});
        push("rst_rs", 8'h01);       pop_check({7'h0, LCD_RS});
        push("rst_rw", 8'h01);       pop_check({7'h0, LCD_RW});
        push("rst_data", 8'h00);     pop_check(LCD_DATA);
        push("lcd_e", 8'h00);        pop_check({7'h0, LCD_E});
        RESET = 1'b1;

        // Strobes accepted during init
        wait_to(10);
        push("init_sel5", 8'h05);    strobe(1'b1, 4'd5, 1'b0, 1'b0); pop_check({4'h0, MODE});
        push("init_home", 8'h00);    strobe(1'b0, 4'd0, 1'b1, 1'b0); pop_check({4'h0, MODE});

        // Init command timing
        wait_to(71);  push("delay_end", 8'h00);  pop_check(LCD_DATA);
        wait_to(72);  push("func_cmd", 8'h3C);   pop_check(LCD_DATA);
        push("func_rs", 8'h00);      pop_check({7'h0, LCD_RS});
        push("func_rw", 8'h00);      pop_check({7'h0, LCD_RW});
        wait_to(102); push("func_end", 8'h3C);   pop_check(LCD_DATA);
        wait_to(103); push("disp_cmd", 8'h0C);   pop_check(LCD_DATA);
        wait_to(133); push("disp_end", 8'h0C);   pop_check(LCD_DATA);
        wait_to(134); push("entry_cmd", 8'h06);  pop_check(LCD_DATA);
        wait_to(163); push("pen_low", 8'h00);    pop_check({7'h0, PROGRAM_EN});
        wait_to(164); push("pen_high", 8'h01);   pop_check({7'h0, PROGRAM_EN});
        wait_to(165); push("ch0_data", 8'h40);   pop_check(LCD_DATA);
        push("ch0_rs", {7'h0, CH_RS[0]});        pop_check({7'h0, LCD_RS});
        push("ch0_rw", {7'h0, CH_RW[0]});        pop_check({7'h0, LCD_RW});

        // SEL to mode 5: MODE at k, MODE_CHG at k+1, pins at k+2
        push("sel5_mode", 8'h05);    strobe(1'b1, 4'd5, 1'b0, 1'b0); pop_check({4'h0, MODE});
        push("sel5_chg_k", 8'h00);   pop_check({7'h0, MODE_CHG});
        @(negedge CLK_1k);
        push("sel5_chg_k1", 8'h01);  pop_check({7'h0, MODE_CHG});
        push("sel5_data_k1", 8'h40); pop_check(LCD_DATA);
        @(negedge CLK_1k);
        push("sel5_chg_k2", 8'h00);  pop_check({7'h0, MODE_CHG});
        push("sel5_data_k2", 8'h41); pop_check(LCD_DATA);
        push("sel5_rs", {7'h0, CH_RS[5]}); pop_check({7'h0, LCD_RS});
        push("sel5_rw", {7'h0, CH_RW[5]}); pop_check({7'h0, LCD_RW});
        push("sel5_pen", 8'h01);     pop_check({7'h0, PROGRAM_EN});
        settle();

        // Invalid and out-of-range selects
        push("sel9_invalid", 8'h00); strobe(1'b1, 4'd9, 1'b0, 1'b0);  pop_check({4'h0, MODE});
        settle();
        push("sel3", 8'h03);         strobe(1'b1, 4'd3, 1'b0, 1'b0);  pop_check({4'h0, MODE});
        settle();
        push("sel14_range", 8'h00);  strobe(1'b1, 4'd14, 1'b0, 1'b0); pop_check({4'h0, MODE});
        settle();

        // BACK from 11, SEL over HOME priority
        push("sel11", 8'h0B);        strobe(1'b1, 4'd11, 1'b0, 1'b0); pop_check({4'h0, MODE});
        settle();
        push("back11", 8'h0A);       strobe(1'b0, 4'd0, 1'b0, 1'b1);  pop_check({4'h0, MODE});
        settle();
        push("sel_over_home", 8'h03); strobe(1'b1, 4'd3, 1'b1, 1'b0); pop_check({4'h0, MODE});
        settle();

        // SEL to current mode: no pulse
        push("sel_same", 8'h03);     strobe(1'b1, 4'd3, 1'b0, 1'b0);  pop_check({4'h0, MODE});
        push("same_chg_k", 8'h00);   pop_check({7'h0, MODE_CHG});
        @(negedge CLK_1k);
        push("same_chg_k1", 8'h00);  pop_check({7'h0, MODE_CHG});
        push("same_pen", 8'h01);     pop_check({7'h0, PROGRAM_EN});
        settle();

        // Channel data to pins: two-cycle latency
        push("ch3_steady", 8'h43);   pop_check(LCD_DATA);
        CH_DATA[3*8 +: 8] = 8'h99;
        @(negedge CLK_1k);
        push("ch3_lat1", 8'h43);     pop_check(LCD_DATA);
        @(negedge CLK_1k);
        push("ch3_lat2", 8'h99);     pop_check(LCD_DATA);

        // BACK in mode 0 with parent 0 holds
        strobe(1'b0, 4'd0, 1'b1, 1'b0);
        settle();
        push("back0_mode", 8'h00);   strobe(1'b0, 4'd0, 1'b0, 1'b1);  pop_check({4'h0, MODE});
        @(negedge CLK_1k);
        push("back0_chg", 8'h00);    pop_check({7'h0, MODE_CHG});

        // Reset from S_PROG, then again from S_DISP
        strobe(1'b1, 4'd7, 1'b0, 1'b0);
        RESET = 1'b0;
        #1;
        push("rst2_mode", 8'h00);    pop_check({4'h0, MODE});
        push("rst2_data", 8'h00);    pop_check(LCD_DATA);
        push("rst2_rs", 8'h01);      pop_check({7'h0, LCD_RS});
        push("rst2_pen", 8'h00);     pop_check({7'h0, PROGRAM_EN});
        @(negedge CLK_1k);
        RESET = 1'b1;
        wait_to(110); push("disp_again", 8'h0C); pop_check(LCD_DATA);
        RESET = 1'b0;
        #1;
        push("rst3_data", 8'h00);    pop_check(LCD_DATA);
        push("rst3_rs", 8'h01);      pop_check({7'h0, LCD_RS});
        push("rst3_rw", 8'h01);      pop_check({7'h0, LCD_RW});
        @(negedge CLK_1k);
        RESET = 1'b1;
        wait_to(71);  push("rst3_delay", 8'h00); pop_check(LCD_DATA);
        wait_to(72);  push("rst3_func", 8'h3C);  pop_check(LCD_DATA);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_mode_arbiter.md
# lcd_mode_arbiter

Parametrised mode controller and character-LCD front end for the watch top level. It tracks the active display mode through select, home and back strobes, using a per-mode parent map. It runs the LCD power-up command sequence, then forwards the active channel's RS/RW/DATA stream to the panel through a registered two-stage mux. It replaces the hard-wired mode case logic and LCD init FSM, and supports any channel count.

## Interface
- N_MODES, 12: number of display channels; mode 0 is home.
- MODE_W, 4: mode code width; 2^MODE_W ≥ N_MODES.
- PWR_DELAY, 70: terminal count of the power-up wait.
- CMD_HOLD, 30: terminal count of each init or clear command.
- FUNC_CMD / DISP_CMD / ENTRY_CMD / CLEAR_CMD, 8'h3C / 8'h0C / 8'h06 / 8'h01: LCD command bytes.
- CLK_1k in 1: sole clock, rising edge.
- RESET in 1: asynchronous, active-low reset.
- SEL_STB in 1: one-cycle pulse; load mode from SEL_CODE.
- SEL_CODE in MODE_W: requested mode.
- HOME_STB in 1: one-cycle pulse; go to mode 0.
- BACK_STB in 1: one-cycle pulse; go to the parent of the current mode.
- PARENT_MAP in N_MODES*MODE_W: parent of mode i at [i*MODE_W +: MODE_W].
- VALID_MAP in N_MODES: bit i set means mode i is selectable.
- CH_RS, CH_RW in N_MODES: per-channel LCD control bits, channel i at bit i.
- CH_DATA in N_MODES*8: per-channel data, channel i at [i*8 +: 8].
- MODE out MODE_W: active mode, registered.
- MODE_CHG out 1: one-cycle pulse in the cycle after MODE changes value.
- PROGRAM_EN out 1: high while channel data is forwarded to the panel.
- LCD_E out 1: equal to CLK_1k (combinational).
- LCD_RS, LCD_RW out 1; LCD_DATA out 8: registered panel outputs.

## Operation
- Reset values: MODE=0, MODE_CHG=0, PROGRAM_EN=0, LCD_RS=1, LCD_RW=1, LCD_DATA=0, FSM=S_DELAY, counter=0.
- Mode next-state is evaluated every cycle. Priority is SEL_STB, then HOME_STB, then BACK_STB, then hold.
  - SEL: if SEL_CODE < N_MODES and VALID_MAP[SEL_CODE], take SEL_CODE; otherwise take 0.
  - HOME: take 0.
  - BACK: take PARENT_MAP entry of MODE; if that entry ≥ N_MODES, take 0. BACK in mode 0 whose parent is 0 leaves MODE unchanged.
  - Strobes are accepted in every FSM state, including during init.
- MODE_CHG fires only when the new value differs from the old value. A SEL to the current mode produces no pulse.
- FSM states: S_DELAY → S_FUNC → S_DISP → S_ENTRY → S_PROG.
  - Each state lasts (terminal count + 1) cycles: S_DELAY uses PWR_DELAY, the others use CMD_HOLD. The counter clears on every state exit.
  - S_FUNC, S_DISP, S_ENTRY drive RS=0, RW=0, DATA = the respective command byte.
  - S_DELAY drives RS=1, RW=1, DATA=0.
  - S_PROG sets PROGRAM_EN=1 and drives the mux output. It is terminal, except for the clear feature.
- Mux stage 1 registers the channel indexed by MODE. Stage 2 (LCD_*) registers stage 1 when in S_PROG; in other states it registers the state's command.
- If MODE ≥ N_MODES (unreachable), channel 0 is used.
- Reset asserted mid-operation returns everything to reset values immediately, and the init sequence restarts from S_DELAY.

## Timing
- Init: the first FUNC_CMD appears on LCD_DATA at the edge after PWR_DELAY+1 cycles in S_DELAY.
- PROGRAM_EN rises (PWR_DELAY+1)+3*(CMD_HOLD+1) cycles after reset release: 164 cycles with defaults.
- Strobe at edge k: MODE updates at edge k, MODE_CHG is high during cycle k+1, stage 1 updates at k+1, LCD pins update at k+2.
- Channel input change to LCD pins: 2-cycle latency in S_PROG.

## Configuration
- LCD_CLEAR_ON_SWITCH_EN defined: a MODE change while in S_PROG or S_CLEAR enters S_CLEAR.
  - S_CLEAR drops PROGRAM_EN, drives RS=0, RW=0, DATA=CLEAR_CMD for CMD_HOLD+1 cycles, then returns to S_PROG.
  - A further mode change during S_CLEAR restarts its counter.
  - Mode changes during init do not trigger S_CLEAR.
- Not defined: S_CLEAR does not exist, and mode changes never affect the FSM or PROGRAM_EN.

## Test plan
- Reset release with defaults: LCD_DATA=3C from cycle 72, 0C from cycle 103, 06 from cycle 134; PROGRAM_EN=1 from cycle 164 onward.
- In S_PROG, CH_DATA[5]=8'h41, VALID_MAP[5]=1, SEL_STB with SEL_CODE=5: MODE=5 one edge later, MODE_CHG one pulse, LCD_DATA=41 two edges after MODE. With LCD_CLEAR_ON_SWITCH_EN defined: 01 for 31 cycles, then 41.
- SEL_CODE=9 with VALID_MAP[9]=0, and separately SEL_CODE=14: MODE=0 in both cases.
- MODE=11, PARENT_MAP[11]=10, BACK_STB: MODE=10. SEL_STB(SEL_CODE=3) together with HOME_STB: MODE=3.
- Reset pulsed low while in S_DISP: outputs return to reset values at once, and 3C reappears 72 cycles after release.
- SEL_STB to the current mode: no MODE_CHG pulse, and no S_CLEAR entry with the macro defined.
